// File: rtl/fmap_arbiter.sv
// fmap_arbiter: coordinate-addressed feature-map store shared by several conv/pool
// clients. Reads and writes of one full channel vector are arbitrated round-robin
// over 2*N_CLIENTS slots (rd0,wr0,rd1,wr1,...). Writes overwrite or accumulate
// (read-modify-write). The map is zeroed after reset and on clear_i.
// Build option: define FMAP_ARB_SATURATE_EN to make accumulation saturate per
// channel; otherwise accumulation wraps in two's complement.
module fmap_arbiter #(
    parameter int N_CLIENTS           = 2,
    parameter int BITS_PER_COORDINATE = 5,
    parameter int FMAP_W              = 32,
    parameter int FMAP_H              = 32,
    parameter int OUT_CHANNELS        = 4,
    parameter int BITS_PER_NEURON     = 8
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            clear_i,
    output logic                                            busy_o,
    input  logic [N_CLIENTS-1:0]                            rd_req_i,
    input  logic [N_CLIENTS*2*BITS_PER_COORDINATE-1:0]      rd_coord_i,
    output logic [N_CLIENTS-1:0]                            rd_gnt_o,
    output logic [N_CLIENTS-1:0]                            rd_valid_o,
    output logic [OUT_CHANNELS*BITS_PER_NEURON-1:0]         rd_data_o,
    input  logic [N_CLIENTS-1:0]                            wr_req_i,
    input  logic [N_CLIENTS*2*BITS_PER_COORDINATE-1:0]      wr_coord_i,
    input  logic [N_CLIENTS*OUT_CHANNELS*BITS_PER_NEURON-1:0] wr_data_i,
    input  logic [N_CLIENTS-1:0]                            wr_acc_i,
    output logic [N_CLIENTS-1:0]                            wr_gnt_o,
    output logic                                            oob_err_o
);
    localparam int BPN   = BITS_PER_NEURON;
    localparam int BPC   = BITS_PER_COORDINATE;
    localparam int W     = OUT_CHANNELS * BPN;
    localparam int C     = 2 * BPC;
    localparam int DEPTH = FMAP_W * FMAP_H;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 2 * N_CLIENTS;
    localparam int PW    = $clog2(SLOTS);
    localparam logic [31:0]      FMAP_W_U = 32'(FMAP_W);
    localparam logic [31:0]      FMAP_H_U = 32'(FMAP_H);
    localparam logic [SLOTS-1:0] SLOT_ONE = {{(SLOTS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_CLEAR  = 2'd0,
        S_IDLE   = 2'd1,
        S_RMW_RD = 2'd2,
        S_RMW_WR = 2'd3
    } state_t;

    // Signed per-channel add, saturating or wrapping depending on the build.
    function automatic logic [BPN-1:0] add_chan(input logic [BPN-1:0] a, input logic [BPN-1:0] b);
`ifdef FMAP_ARB_SATURATE_EN
        logic [BPN:0] sum;
        sum = {a[BPN-1], a} + {b[BPN-1], b};
        if (sum[BPN] != sum[BPN-1]) begin
            add_chan = {sum[BPN], {(BPN-1){~sum[BPN]}}};
        end else begin
            add_chan = sum[BPN-1:0];
        end
`else
        add_chan = a + b;
`endif
    endfunction

    state_t               state_r, state_nx_s;
    logic [AW-1:0]        clr_cnt_r;
    logic                 clr_pend_r;
    logic                 clear_req_s;
    logic [PW-1:0]        rr_ptr_r;
    logic [SLOTS-1:0]     req_s, gnt_vec_s;
    logic [PW-1:0]        gnt_idx_s;
    logic                 found_s, grant_en_s, acc_gnt_s;
    logic [C-1:0]         sel_coord_s;
    logic [W-1:0]         sel_data_s;
    logic                 sel_acc_s, sel_is_wr_s, sel_oob_s;
    logic [N_CLIENTS-1:0] sel_client_s;
    logic [BPC-1:0]       sel_x_s, sel_y_s;
    logic [AW-1:0]        sel_addr_s;
    logic [AW-1:0]        op_addr_r;
    logic [W-1:0]         op_data_r;
    logic                 op_oob_r;
    logic [N_CLIENTS-1:0] op_client_r;
    logic                 s1_rd_r, s1_wr_r;
    logic [W-1:0]         mem_r [DEPTH];
    logic [W-1:0]         rmw_q_r, acc_sum_s;
    logic [N_CLIENTS-1:0] rd_valid_r;
    logic [W-1:0]         rd_data_r;
    logic                 oob_err_r;

    // Interleave read/write requests into slot order rd0,wr0,rd1,wr1,...
    always_comb begin
        req_s = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            req_s[2*k]   = rd_req_i[k];
            req_s[2*k+1] = wr_req_i[k];
        end
    end

    // Round-robin search from rr_ptr_r; the lowest rotated distance wins.
    always_comb begin
        found_s   = 1'b0;
        gnt_idx_s = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            gnt_idx_s = req_s[(int'(rr_ptr_r) + i) % SLOTS] ? PW'((int'(rr_ptr_r) + i) % SLOTS) : gnt_idx_s;
            found_s   = found_s | req_s[(int'(rr_ptr_r) + i) % SLOTS];
        end
    end

    assign clear_req_s = clear_i | clr_pend_r;
    assign grant_en_s  = (state_r == S_IDLE) & ~clear_req_s & found_s;
    assign gnt_vec_s   = grant_en_s ? (SLOT_ONE << gnt_idx_s) : '0;

    // Select the granted client's coordinate, data and mode; split one-hot grants.
    always_comb begin
        sel_coord_s  = '0;
        sel_data_s   = '0;
        sel_acc_s    = 1'b0;
        sel_is_wr_s  = 1'b0;
        sel_client_s = '0;
        rd_gnt_o     = '0;
        wr_gnt_o     = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            rd_gnt_o[k]     = gnt_vec_s[2*k];
            wr_gnt_o[k]     = gnt_vec_s[2*k+1];
            sel_client_s[k] = gnt_vec_s[2*k] | gnt_vec_s[2*k+1];
            sel_is_wr_s     = sel_is_wr_s | gnt_vec_s[2*k+1];
            sel_acc_s       = sel_acc_s | (gnt_vec_s[2*k+1] & wr_acc_i[k]);
            sel_coord_s     = sel_coord_s | (rd_coord_i[k*C +: C] & {C{gnt_vec_s[2*k]}})
                                          | (wr_coord_i[k*C +: C] & {C{gnt_vec_s[2*k+1]}});
            sel_data_s      = sel_data_s | (wr_data_i[k*W +: W] & {W{gnt_vec_s[2*k+1]}});
        end
    end

    assign sel_x_s    = sel_coord_s[C-1:BPC];
    assign sel_y_s    = sel_coord_s[BPC-1:0];
    assign sel_oob_s  = (32'(sel_x_s) >= FMAP_W_U) || (32'(sel_y_s) >= FMAP_H_U);
    assign sel_addr_s = AW'(32'(sel_y_s) * FMAP_W_U + 32'(sel_x_s));
    assign acc_gnt_s  = grant_en_s & sel_is_wr_s & sel_acc_s;

    // Per-channel accumulate of the stored vector with the held write data.
    always_comb begin
        acc_sum_s = '0;
        for (int ch = 0; ch < OUT_CHANNELS; ch++) begin
            acc_sum_s[ch*BPN +: BPN] = add_chan(rmw_q_r[ch*BPN +: BPN], op_data_r[ch*BPN +: BPN]);
        end
    end

    // Next-state logic: clear sweep, idle arbitration, two-cycle RMW.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_CLEAR: begin
                if (clr_cnt_r == AW'(DEPTH - 1)) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_CLEAR;
                end
            end
            S_IDLE: begin
                if (clear_req_s) begin
                    state_nx_s = S_CLEAR;
                end else if (acc_gnt_s) begin
                    state_nx_s = S_RMW_RD;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_RMW_RD: state_nx_s = S_RMW_WR;
            S_RMW_WR: state_nx_s = S_IDLE;
            default:  state_nx_s = S_CLEAR;
        endcase
    end

    // Control state: FSM, clear counter, deferred clear, round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_CLEAR;
            clr_cnt_r  <= '0;
            clr_pend_r <= 1'b0;
            rr_ptr_r   <= '0;
        end else begin
            state_r   <= state_nx_s;
            clr_cnt_r <= ((state_r == S_CLEAR) && (state_nx_s == S_CLEAR)) ? clr_cnt_r + AW'(1) : '0;
            if (((state_r == S_RMW_RD) || (state_r == S_RMW_WR)) && clear_i) begin
                clr_pend_r <= 1'b1;
            end else if (state_nx_s == S_CLEAR) begin
                clr_pend_r <= 1'b0;
            end else begin
                clr_pend_r <= clr_pend_r;
            end
            if (grant_en_s) begin
                rr_ptr_r <= (gnt_idx_s == PW'(SLOTS - 1)) ? '0 : gnt_idx_s + PW'(1);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Capture the granted operation; drive registered read results and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_rd_r     <= 1'b0;
            s1_wr_r     <= 1'b0;
            op_addr_r   <= '0;
            op_data_r   <= '0;
            op_oob_r    <= 1'b0;
            op_client_r <= '0;
            rd_valid_r  <= '0;
            rd_data_r   <= '0;
            oob_err_r   <= 1'b0;
        end else begin
            s1_rd_r    <= grant_en_s & ~sel_is_wr_s;
            s1_wr_r    <= grant_en_s & sel_is_wr_s & ~sel_acc_s;
            if (grant_en_s) begin
                op_addr_r   <= sel_addr_s;
                op_data_r   <= sel_data_s;
                op_oob_r    <= sel_oob_s;
                op_client_r <= sel_client_s;
            end else begin
                op_addr_r   <= op_addr_r;
                op_data_r   <= op_data_r;
                op_oob_r    <= op_oob_r;
                op_client_r <= op_client_r;
            end
            rd_valid_r <= s1_rd_r ? op_client_r : '0;
            rd_data_r  <= (s1_rd_r && !op_oob_r) ? mem_r[op_addr_r] : '0;
            oob_err_r  <= oob_err_r | (grant_en_s & sel_oob_s);
        end
    end

    // Single-port map: clear sweep, overwrite, RMW write, otherwise RMW read.
    always_ff @(posedge clk) begin
        if (state_r == S_CLEAR) begin
            mem_r[clr_cnt_r] <= '0;
        end else if (s1_wr_r && !op_oob_r) begin
            mem_r[op_addr_r] <= op_data_r;
        end else if ((state_r == S_RMW_WR) && !op_oob_r) begin
            mem_r[op_addr_r] <= acc_sum_s;
        end else begin
            rmw_q_r <= mem_r[op_addr_r];
        end
    end

    assign busy_o     = (state_r == S_CLEAR);
    assign rd_valid_o = rd_valid_r;
    assign rd_data_o  = rd_data_r;
    assign oob_err_o  = oob_err_r;

endmodule

// File: tb/tb_fmap_arbiter.sv
// Directed bench for fmap_arbiter. Coordinates are 6 bits wide here so that
// out-of-range x/y (32) can be presented; every other parameter is default.
module tb_fmap_arbiter;
    localparam int N = 2;
    localparam int C = 12;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           clear_i = 1'b0;
    logic           busy_o;
    logic [N-1:0]   rd_req = '0, wr_req = '0, wr_acc = '0;
    logic [N*C-1:0] rd_coord = '0, wr_coord = '0;
    logic [N*W-1:0] wr_data = '0;
    logic [N-1:0]   rd_gnt_o, rd_valid_o, wr_gnt_o;
    logic [W-1:0]   rd_data_o;
    logic           oob_err_o;
    logic [3:0]     gvec;

    int n_cmp = 0;
    int n_bad = 0;
    int n;
    logic [31:0] d;
    logic [1:0]  v;
    logic [3:0]  one4 = 4'b0001;
    logic [31:0] acc_exp;

    fmap_arbiter #(.BITS_PER_COORDINATE(6)) dut (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .busy_o(busy_o),
        .rd_req_i(rd_req), .rd_coord_i(rd_coord), .rd_gnt_o(rd_gnt_o),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
        .wr_req_i(wr_req), .wr_coord_i(wr_coord), .wr_data_i(wr_data),
        .wr_acc_i(wr_acc), .wr_gnt_o(wr_gnt_o), .oob_err_o(oob_err_o)
    );

    always #5 clk = ~clk;

    // Slot view of the grants: bit0 rd0, bit1 wr0, bit2 rd1, bit3 wr1.
    assign gvec = {wr_gnt_o[1], rd_gnt_o[1], wr_gnt_o[0], rd_gnt_o[0]};

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge after raising a request; returns at negedge+1 of the grant cycle.
    task automatic wait_gnt(input int slot);
        int k = 0;
        #1;
        while (!gvec[slot] && k < 3000) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_val("gnt_wait", {63'd0, gvec[slot]}, 64'd1);
    endtask

    // Starts at a negedge; returns at the negedge of grant cycle + 1 with request dropped.
    task automatic write_op(input int k, input logic [5:0] x, input logic [5:0] y,
                            input logic [31:0] dat, input logic acc);
        wr_req[k] = 1'b1;
        wr_coord[k*C +: C] = {x, y};
        wr_data[k*W +: W] = dat;
        wr_acc[k] = acc;
        wait_gnt(2*k+1);
        @(negedge clk);
        wr_req[k] = 1'b0;
        wr_acc[k] = 1'b0;
    endtask

    // Starts at a negedge; samples the result at the negedge of grant cycle + 2.
    task automatic read_op(input int k, input logic [5:0] x, input logic [5:0] y,
                           output logic [31:0] dat, output logic [1:0] vld);
        rd_req[k] = 1'b1;
        rd_coord[k*C +: C] = {x, y};
        wait_gnt(2*k);
        @(negedge clk);
        rd_req[k] = 1'b0;
        @(negedge clk);
        dat = rd_data_o;
        vld = rd_valid_o;
    endtask

    // Counts consecutive negedge samples with busy_o high, starting now.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy_o && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    // Absolute time limit on the whole run.
    initial begin
        #600000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Directed sequence.
    initial begin
`ifdef FMAP_ARB_SATURATE_EN
        acc_exp = 32'h7F7F7F7F;
`else
        acc_exp = 32'h90909090;
`endif
        repeat (3) @(negedge clk);
        check_val("rst_busy", {63'd0, busy_o}, 64'd1);
        check_val("rst_valid", {62'd0, rd_valid_o}, 64'd0);
        check_val("rst_data", {32'd0, rd_data_o}, 64'd0);
        check_val("rst_oob", {63'd0, oob_err_o}, 64'd0);
        check_val("rst_gnt", {60'd0, gvec}, 64'd0);

        rst_n = 1'b1;
        count_busy(n);
        check_val("boot_clear_len", 64'(n), 64'd1024);
        read_op(0, 6'd31, 6'd31, d, v);
        check_val("rd_31_31_vld", {62'd0, v}, 64'd1);
        check_val("rd_31_31_data", {32'd0, d}, 64'd0);

        // Overwrite by client0, read by client1 in the very next cycle.
        write_op(0, 6'd3, 6'd5, 32'h04030201, 1'b0);
        rd_req[1] = 1'b1;
        rd_coord[C +: C] = {6'd3, 6'd5};
        #1;
        check_val("raw_rd_gnt", {60'd0, gvec}, 64'h4);
        @(negedge clk);
        rd_req[1] = 1'b0;
        check_val("raw_vld_early", {62'd0, rd_valid_o}, 64'd0);
        @(negedge clk);
        check_val("raw_vld", {62'd0, rd_valid_o}, 64'h2);
        check_val("raw_data", {32'd0, rd_data_o}, 64'h04030201);

        // Accumulate 0x70.. onto 0x20.. at (1,1); a pending read must wait out the RMW.
        @(negedge clk);
        write_op(0, 6'd1, 6'd1, 32'h20202020, 1'b0);
        wr_req[1] = 1'b1;
        wr_acc[1] = 1'b1;
        wr_coord[C +: C] = {6'd1, 6'd1};
        wr_data[W +: W] = 32'h70707070;
        wait_gnt(3);
        @(negedge clk);
        wr_req[1] = 1'b0;
        wr_acc[1] = 1'b0;
        rd_req[0] = 1'b1;
        rd_coord[0 +: C] = {6'd1, 6'd1};
        #1;
        check_val("rmw_nognt_1", {60'd0, gvec}, 64'd0);
        @(negedge clk);
        #1;
        check_val("rmw_nognt_2", {60'd0, gvec}, 64'd0);
        @(negedge clk);
        #1;
        check_val("rmw_resume", {60'd0, gvec}, 64'd1);
        @(negedge clk);
        rd_req[0] = 1'b0;
        @(negedge clk);
        check_val("acc_vld", {62'd0, rd_valid_o}, 64'd1);
        check_val("acc_data", {32'd0, rd_data_o}, {32'd0, acc_exp});

        // Grant wr1 alone so the pointer sits at rd0, then load all four slots.
        @(negedge clk);
        write_op(1, 6'd2, 6'd2, 32'h11223344, 1'b0);
        rd_req = 2'b11;
        wr_req = 2'b11;
        rd_coord = {6'd11, 6'd11, 6'd10, 6'd10};
        wr_coord = {6'd11, 6'd11, 6'd10, 6'd10};
        wr_data = {32'hBBBBBBBB, 32'hAAAAAAAA};
        for (int i = 0; i < 8; i++) begin
            #1;
            check_val($sformatf("rr_grant_%0d", i), {60'd0, gvec}, {60'd0, one4 << (i % 4)});
            @(negedge clk);
        end
        rd_req = 2'b00;
        wr_req = 2'b00;
        repeat (3) @(negedge clk);

        // Out-of-range read (32,0): zero data, normal timing, sticky error from t+1.
        rd_req[0] = 1'b1;
        rd_coord[0 +: C] = {6'd32, 6'd0};
        #1;
        check_val("oob_gnt", {60'd0, gvec}, 64'd1);
        check_val("oob_err_pre", {63'd0, oob_err_o}, 64'd0);
        @(negedge clk);
        rd_req[0] = 1'b0;
        check_val("oob_err_t1", {63'd0, oob_err_o}, 64'd1);
        @(negedge clk);
        check_val("oob_rd_vld", {62'd0, rd_valid_o}, 64'd1);
        check_val("oob_rd_data", {32'd0, rd_data_o}, 64'd0);

        // Out-of-range write (0,32) would alias address 0 if not dropped.
        write_op(1, 6'd0, 6'd32, 32'hDEADBEEF, 1'b0);
        read_op(0, 6'd0, 6'd0, d, v);
        check_val("oob_wr_dropped", {32'd0, d}, 64'd0);
        read_op(1, 6'd3, 6'd5, d, v);
        check_val("map_keep_3_5", {32'd0, d}, 64'h04030201);
        check_val("map_keep_vld", {62'd0, v}, 64'h2);

        // clear_i during S_RMW_WR: deferred until idle, then a full sweep.
        @(negedge clk);
        wr_req[0] = 1'b1;
        wr_acc[0] = 1'b1;
        wr_coord[0 +: C] = {6'd3, 6'd5};
        wr_data[0 +: W] = 32'h01010101;
        wait_gnt(1);
        @(negedge clk);
        wr_req[0] = 1'b0;
        wr_acc[0] = 1'b0;
        @(negedge clk);
        clear_i = 1'b1;
        check_val("clr_rmw_busy", {63'd0, busy_o}, 64'd0);
        @(negedge clk);
        clear_i = 1'b0;
        check_val("clr_idle_gap", {63'd0, busy_o}, 64'd0);
        @(negedge clk);
        count_busy(n);
        check_val("clr_len", 64'(n), 64'd1024);
        read_op(1, 6'd3, 6'd5, d, v);
        check_val("clr_zeroed", {32'd0, d}, 64'd0);

        // Reset in the middle of a clear restarts the sweep from address 0.
        @(negedge clk);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        repeat (300) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("midclr_rst_busy", {63'd0, busy_o}, 64'd1);
        check_val("midclr_rst_oob", {63'd0, oob_err_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(n);
        check_val("midclr_len", 64'(n), 64'd1024);
        read_op(0, 6'd1, 6'd1, d, v);
        check_val("post_rst_zero", {32'd0, d}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
